// File: rtl/symbol_framer.sv
// ---------------------------------------------------------------------------
// symbol_framer
//
// Turns an upstream byte stream into a framed 8b symbol stream:
//   - a packet is wrapped as  STP|SDP, payload..., END
//   - idle filler (IDL) is sent whenever there is nothing to frame
//   - a skip ordered set (COM followed by SKP_LEN x SKP) is inserted
//     periodically, but only between packets
//
// Parameters
//   SKP_INTERVAL  cycles between skip ordered set requests (8..65535)
//   SKP_LEN       SKP symbols following each COM (1..5)
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high reset
//   valid_in   upstream byte valid
//   data_in    upstream payload byte
//   last_in    data_in is the final byte of the packet
//   type_in    packet type at packet start: 0 = TLP (STP), 1 = DLLP (SDP)
//   ready_out  byte accepted when valid_in && ready_out at a rising clk
//   data_out   registered symbol
//   k_out      data_out is a control symbol
//   valid_out  data_out is a framed or ordered-set symbol (0 on idle filler)
//
// Handshake: an upstream byte is transferred on a rising clk where
// valid_in && ready_out. ready_out depends on the FSM state only (it is
// high throughout DATA, even while valid_in is low), so it never loops
// back from valid_in. Upstream must hold data_in/last_in/type_in stable
// until the byte is transferred; type_in is only looked at in START.
//
// All FSM context (state, ordered-set position, skip scheduler) lives in
// the packed struct 'ctl' so it can be observed or probed as one signal.
// ---------------------------------------------------------------------------
module symbol_framer #(
    parameter int unsigned SKP_INTERVAL = 64,
    parameter int unsigned SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    input  logic       last_in,
    input  logic       type_in,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       k_out,
    output logic       valid_out
);

    // Control codes
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    // Skip request fires when the counter reaches SKP_INTERVAL-1.
    localparam logic [15:0] SKP_LIMIT = 16'(SKP_INTERVAL - 1);
    // Index of the final SKP symbol of an ordered set.
    localparam logic [2:0]  SYM_LAST  = 3'(SKP_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_END     = 3'd3,
        ST_SKP_COM = 3'd4,
        ST_SKP_SYM = 3'd5
    } state_t;

    typedef struct packed {
        state_t      state;       // framer FSM state
        logic [2:0]  sym_cnt;     // SKP symbols already sent in this set
        logic [15:0] skp_cnt;     // cycles since the last COM
        logic        skp_pending; // skip ordered set requested, not yet sent
    } ctl_t;

    ctl_t        ctl;
    logic [15:0] skp_cnt_inc;

    assign skp_cnt_inc = ctl.skp_cnt + 16'd1;

    // Only DATA consumes upstream bytes.
    assign ready_out = (ctl.state == ST_DATA);

    // -----------------------------------------------------------------------
    // Framer FSM with registered symbol outputs. The symbol registered at an
    // edge is the one belonging to the state the FSM is leaving at that edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl.state       <= ST_IDLE;
            ctl.sym_cnt     <= 3'd0;
            ctl.skp_cnt     <= 16'd0;
            ctl.skp_pending <= 1'b0;
            data_out        <= SYM_IDL;
            k_out           <= 1'b1;
            valid_out       <= 1'b0;
        end else begin
            // Skip scheduler: counts every cycle outside the ordered set and
            // holds its value once a request is pending, so a long packet
            // cannot wrap it. Sending COM restarts the interval.
            if (ctl.state == ST_SKP_COM) begin
                ctl.skp_cnt     <= 16'd0;
                ctl.skp_pending <= 1'b0;
            end else if ((ctl.state != ST_SKP_SYM) && !ctl.skp_pending) begin
                ctl.skp_cnt <= skp_cnt_inc;
                if (skp_cnt_inc == SKP_LIMIT) begin
                    ctl.skp_pending <= 1'b1;
                end
            end

            case (ctl.state)
                ST_IDLE: begin
                    data_out  <= SYM_IDL;
                    k_out     <= 1'b1;
                    valid_out <= 1'b0;
                    // A pending skip wins over a waiting packet. The packet
                    // byte is not consumed here; START only emits the header.
                    if (ctl.skp_pending) begin
                        ctl.state <= ST_SKP_COM;
                    end else if (valid_in) begin
                        ctl.state <= ST_START;
                    end
                end

                ST_START: begin
                    data_out  <= type_in ? SYM_SDP : SYM_STP;
                    k_out     <= 1'b1;
                    valid_out <= 1'b1;
                    ctl.state <= ST_DATA;
                end

                ST_DATA: begin
                    if (valid_in) begin
                        // Payload is passed through untouched even when it
                        // matches a control code; k_out=0 disambiguates it.
                        data_out  <= data_in;
                        k_out     <= 1'b0;
                        valid_out <= 1'b1;
                        if (last_in) begin
                            ctl.state <= ST_END;
                        end
                    end else begin
                        // Underrun: pad with idle filler and keep waiting.
                        data_out  <= SYM_IDL;
                        k_out     <= 1'b1;
                        valid_out <= 1'b0;
                    end
                end

                ST_END: begin
                    data_out  <= SYM_END;
                    k_out     <= 1'b1;
                    valid_out <= 1'b1;
                    // Going through IDLE (rather than START) guarantees at
                    // least one IDL between back-to-back packets.
                    ctl.state <= ctl.skp_pending ? ST_SKP_COM : ST_IDLE;
                end

                ST_SKP_COM: begin
                    data_out    <= SYM_COM;
                    k_out       <= 1'b1;
                    valid_out   <= 1'b1;
                    ctl.sym_cnt <= 3'd0;
                    ctl.state   <= ST_SKP_SYM;
                end

                ST_SKP_SYM: begin
                    data_out  <= SYM_SKP;
                    k_out     <= 1'b1;
                    valid_out <= 1'b1;
                    if (ctl.sym_cnt == SYM_LAST) begin
                        ctl.sym_cnt <= 3'd0;
                        ctl.state   <= ST_IDLE;
                    end else begin
                        ctl.sym_cnt <= ctl.sym_cnt + 3'd1;
                    end
                end

                default: begin
                    data_out  <= SYM_IDL;
                    k_out     <= 1'b1;
                    valid_out <= 1'b0;
                    ctl.state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/symbol_framer.md
SYMBOL_FRAMER -- requirements
Module: symbol_framer

Interface
REQ-001 Parameter SKP_INTERVAL, default 64: cycles between skip ordered set requests; legal range 8..65535.
REQ-002 Parameter SKP_LEN, default 3: SKP symbols following each COM; legal range 1..5.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  upstream byte valid.
REQ-006 data_in  input  8  upstream payload byte.
REQ-007 last_in  input  1  qualifies data_in as final byte of packet.
REQ-008 type_in  input  1  packet type (0 = TLP, framed by STP; 1 = DLLP, framed by SDP); sampled only at packet start.
REQ-009 ready_out  output  1  byte accepted when valid_in && ready_out at rising clk.
REQ-010 data_out  output  8  registered symbol stream.
REQ-011 k_out  output  1  data_out is a control symbol.
REQ-012 valid_out  output  1  data_out is a framed or ordered-set symbol (0 when data_out is idle filler).

Function
REQ-013 Control codes: COM=8'hBC, SKP=8'h1C, STP=8'hFB, SDP=8'h5C, END=8'hFD, IDL=8'h7C.
REQ-014 FSM states: IDLE, START, DATA, END, SKP_COM, SKP_SYM.
REQ-015 ready_out = 1 only in state DATA, combinational from state.
REQ-016 data_out/k_out/valid_out registered; value after edge n reflects state and inputs sampled at edge n.
REQ-017 IDLE: emit IDL, k_out=1, valid_out=0.
REQ-018 IDLE -> SKP_COM when skp_pending=1, regardless of valid_in (skip has priority).
REQ-019 IDLE -> START when skp_pending=0 and valid_in=1; data_in not consumed in this cycle.
REQ-020 START: emit STP (type_in=0) or SDP (type_in=1), k_out=1, valid_out=1; always -> DATA next cycle.
REQ-021 DATA with valid_in=1: emit data_in, k_out=0, valid_out=1; if last_in=1 -> END, else remain in DATA.
REQ-022 DATA with valid_in=0 (underrun): emit IDL, k_out=1, valid_out=0; remain in DATA; packet resumes when valid_in returns.
REQ-023 Payload bytes equal to any control code are transmitted unchanged with k_out=0.
REQ-024 END: emit END, k_out=1, valid_out=1; -> SKP_COM if skp_pending, else IDLE.
REQ-025 Back-to-back packets: END is followed by at least one IDL cycle before the next STP/SDP.
REQ-026 Skip counter: 16 bits, increments every cycle outside SKP_COM/SKP_SYM; skp_pending sets when counter reaches SKP_INTERVAL-1; counter saturates while pending.
REQ-027 Skip ordered sets are never inserted inside a packet (START..END); a pending skip waits for END or IDLE.
REQ-028 SKP_COM: emit COM, k_out=1, valid_out=1; clear skp_pending and counter; -> SKP_SYM.
REQ-029 SKP_SYM: emit SKP, k_out=1, valid_out=1, for exactly SKP_LEN cycles; then -> IDLE.
REQ-030 ready_out = 0 throughout START, END, SKP_COM, SKP_SYM, IDLE; upstream holds data_in/last_in/type_in until accepted.

Reset
REQ-031 While reset=1: state IDLE, data_out=IDL, k_out=1, valid_out=0, ready_out=0, skip counter 0, skp_pending=0.
REQ-032 Reset asserted mid-packet or mid-skip aborts immediately; no END emitted; first symbol after deassertion is IDL.

Verification
REQ-033 Reset release, valid_in=0 for 10 cycles -> data_out=8'h7C, k_out=1, valid_out=0 every cycle.
REQ-034 TLP bytes 11,22,33 (last on 33), type_in=0 -> FB(k), 11,22,33 (k=0), FD(k), then 7C; ready_out high exactly 3 accepting cycles.
REQ-035 DLLP payload 8'hBC,8'hFD with valid_in gap of 2 cycles between them -> 5C(k), BC(k=0), 7C,7C (valid_out=0), FD(k=0), FD(k=1).
REQ-036 SKP_INTERVAL=8, idle stream -> COM then SKP x3 (k=1, valid_out=1) at cycle 8 after reset release, repeating every 12 cycles.
REQ-037 Skip pending during a 20-byte packet -> packet uninterrupted; BC,1C,1C,1C immediately after FD; then IDL/next packet.
REQ-038 Reset pulse after 2nd payload byte -> outputs return to reset values asynchronously; next packet starts with fresh STP.
